reg_select_sb: RTL and testbench

- Parametrised register select/encode unit for the datapath control path.
- Latches the instruction word and decodes the Ra/Rb/Rc fields to one-hot register-enable vectors.
- Produces the extended immediate and tracks in-flight register writes with a busy scoreboard.
- Raises a stall when a busy register is read or re-reserved; sits between the control unit and the register file / bus mux.

---
 rtl/reg_select_sb_pkg.sv | 34 +++
 rtl/reg_select_sb_if.sv | 44 ++++
 rtl/reg_select_sb_scoreboard.sv | 48 ++++
 rtl/reg_select_sb.sv | 97 +++++++++
 tb/tb_reg_select_sb.sv | 355 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_select_sb_pkg.sv
// Shared types, default field layout and helpers for the register select unit.
// Widths here are the default configuration the top is built around.
package reg_sel_pkg;

    localparam int DATA_W_D = 32;
    localparam int NREGS_D  = 16;
    localparam int AW_D     = $clog2(NREGS_D);
    localparam int RA_LSB_D = 23;
    localparam int RB_LSB_D = 19;
    localparam int RC_LSB_D = 15;
    localparam int IMM_W    = 19;

    typedef logic [NREGS_D-1:0]  regvec_t;
    typedef logic [DATA_W_D-1:0] word_t;
    typedef logic [AW_D-1:0]     ridx_t;

    function automatic regvec_t onehot(input ridx_t idx);
        regvec_t r;
        r = '0;
        r[idx] = 1'b1;
        return r;
    endfunction

    function automatic word_t ext(input logic [IMM_W-1:0] imm,
                                  input logic sgn);
        word_t r;
        if (sgn)
            r = {{(DATA_W_D-IMM_W){imm[IMM_W-1]}}, imm};
        else
            r = {{(DATA_W_D-IMM_W){1'b0}}, imm};
        return r;
    endfunction

endpackage

// File: rtl/reg_select_sb_if.sv
// Control-unit to register-select bundle.
// master = control side, slave = the select unit.
interface reg_select_sb_if #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 16,
    parameter int AW     = $clog2(NREGS)
);
    logic              ir_load;
    logic [DATA_W-1:0] ir_in;
    logic              Gra;
    logic              Grb;
    logic              Grc;
    logic              Rin;
    logic              Rout;
    logic              BAout;
    logic              imm_signed;
    logic              sb_reserve;
    logic              sb_release;
    logic [AW-1:0]     sb_idx;

    logic [NREGS-1:0]  regin;
    logic [NREGS-1:0]  regout;
    logic              ba_zero;
    logic [DATA_W-1:0] imm_out;
    logic              stall;
    logic              sel_err;
    logic [NREGS-1:0]  busy;
    logic [DATA_W-1:0] ir_q;

    modport master (
        output ir_load, ir_in, Gra, Grb, Grc, Rin, Rout, BAout,
        output imm_signed, sb_reserve, sb_release, sb_idx,
        input  regin, regout, ba_zero, imm_out, stall, sel_err,
        input  busy, ir_q
    );

    modport slave (
        input  ir_load, ir_in, Gra, Grb, Grc, Rin, Rout, BAout,
        input  imm_signed, sb_reserve, sb_release, sb_idx,
        output regin, regout, ba_zero, imm_out, stall, sel_err,
        output busy, ir_q
    );

endinterface

// File: rtl/reg_select_sb_scoreboard.sv
// Busy scoreboard: one bit per register, reserve/release and hazard detect.
// A release of the register being read or re-reserved bypasses the hazard.
module sb_scoreboard #(
    parameter int NREGS = 16,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             reserve,
    input  logic [AW-1:0]    ra,
    input  logic             rel,
    input  logic [AW-1:0]    rel_idx,
    input  logic             rd_req,
    input  logic             sel_v,
    input  logic [AW-1:0]    sel_idx,
    output logic [NREGS-1:0] busy,
    output logic             stall
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic             rd_haz;
    logic             waw;

    always_comb begin
        rd_haz = rd_req & sel_v & busy_q[sel_idx]
               & ~(rel & (rel_idx == sel_idx));
        waw    = reserve & busy_q[ra]
               & ~(rel & (rel_idx == ra));
        stall  = rd_haz | waw;
        busy_d = busy_q;
        if (rel)
            busy_d[rel_idx] = 1'b0;
        // set after clear so a same-index reserve wins
        if (reserve && !stall)
            busy_d[ra] = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (clear)
            busy_q <= '0;
        else
            busy_q <= busy_d;
    end

    assign busy = busy_q;

endmodule

// File: rtl/reg_select_sb.sv
// Register select/encode unit: IR latch, Ra/Rb/Rc one-hot decode,
// immediate extension and busy scoreboard stall.
module reg_select_sb
    import reg_sel_pkg::*;
#(
    parameter int DATA_W = DATA_W_D,
    parameter int NREGS  = NREGS_D,
    parameter int RA_LSB = RA_LSB_D,
    parameter int RB_LSB = RB_LSB_D,
    parameter int RC_LSB = RC_LSB_D,
    parameter int IMM_W  = reg_sel_pkg::IMM_W
) (
    input  logic           clock,
    input  logic           clear,
    reg_select_sb_if.slave bus
);

    localparam int AW = $clog2(NREGS);

    if (DATA_W != DATA_W_D || NREGS != NREGS_D
        || IMM_W != reg_sel_pkg::IMM_W) begin : g_cfg_chk
        $error("reg_select_sb: widths must match reg_sel_pkg");
    end

    logic [DATA_W-1:0] ir_q;
    logic [AW-1:0]     ra;
    logic [AW-1:0]     rb;
    logic [AW-1:0]     rc;
    logic [AW-1:0]     sel_idx;
    logic              sel_v;
    logic [NREGS-1:0]  dec;
    logic              rd_req;
    logic              stall;

    always_ff @(posedge clock) begin
        if (clear)
            ir_q <= '0;
        else if (bus.ir_load)
            ir_q <= bus.ir_in;
    end

    assign ra = ir_q[RA_LSB +: AW];
    assign rb = ir_q[RB_LSB +: AW];
    assign rc = ir_q[RC_LSB +: AW];

    always_comb begin
        sel_idx = '0;
        sel_v   = 1'b0;
        if (bus.Gra) begin
            sel_idx = ra;
            sel_v   = 1'b1;
        end else if (bus.Grb) begin
            sel_idx = rb;
            sel_v   = 1'b1;
        end else if (bus.Grc) begin
            sel_idx = rc;
            sel_v   = 1'b1;
        end
    end

    assign rd_req = bus.Rout | bus.BAout;

    sb_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_sb (
        .clock   (clock),
        .clear   (clear),
        .reserve (bus.sb_reserve),
        .ra      (ra),
        .rel     (bus.sb_release),
        .rel_idx (bus.sb_idx),
        .rd_req  (rd_req),
        .sel_v   (sel_v),
        .sel_idx (sel_idx),
        .busy    (bus.busy),
        .stall   (stall)
    );

    always_comb begin
        dec = '0;
        if (sel_v)
            dec = onehot(sel_idx);
    end

    // two or more strobes: priority result is still driven
    assign bus.sel_err = (bus.Gra & bus.Grb) | (bus.Gra & bus.Grc)
                       | (bus.Grb & bus.Grc);

    assign bus.regin   = (bus.Rin && !stall) ? dec : '0;
    assign bus.regout  = (rd_req && !stall) ? dec : '0;
    assign bus.ba_zero = bus.BAout & sel_v & (sel_idx == '0) & ~stall;
    assign bus.imm_out = ext(ir_q[IMM_W-1:0], bus.imm_signed);
    assign bus.stall   = stall;
    assign bus.ir_q    = ir_q;

endmodule

// File: tb/tb_reg_select_sb.sv
// Directed bench for reg_select_sb: decode, priority, R0 base,
// immediate extension and scoreboard hazards.
module tb_reg_select_sb;

    logic clock;
    logic clear;
    int   errors;
    int   checks;

    reg_select_sb_if #(.DATA_W(32), .NREGS(16)) bus ();

    reg_select_sb dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.ir_load    = 1'b0;
        bus.Gra        = 1'b0;
        bus.Grb        = 1'b0;
        bus.Grc        = 1'b0;
        bus.Rin        = 1'b0;
        bus.Rout       = 1'b0;
        bus.BAout      = 1'b0;
        bus.imm_signed = 1'b0;
        bus.sb_reserve = 1'b0;
        bus.sb_release = 1'b0;
        bus.sb_idx     = '0;
    endtask

    task automatic load_ir(input logic [31:0] w);
        bus.ir_in   = w;
        bus.ir_load = 1'b1;
        tick();
        bus.ir_load = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        idle();
        bus.ir_in = 32'hDEAD_BEEF;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        #1;
        checks++;
        if (bus.ir_q !== 32'h0) begin
            errors++;
            $display("FAIL reset_ir got=%h exp=%h", bus.ir_q, 32'h0);
        end
        checks++;
        if (bus.busy !== 16'h0) begin
            errors++;
            $display("FAIL reset_busy got=%h exp=%h", bus.busy, 16'h0);
        end
        checks++;
        if ({bus.regin, bus.regout} !== 32'h0 || bus.imm_out !== 32'h0) begin
            errors++;
            $display("FAIL reset_outs regin=%h regout=%h imm=%h exp=0",
                     bus.regin, bus.regout, bus.imm_out);
        end
        checks++;
        if ({bus.ba_zero, bus.stall, bus.sel_err} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got=%b exp=000",
                     {bus.ba_zero, bus.stall, bus.sel_err});
        end
    endtask

    task automatic test_load_decode();
        idle();
        load_ir(32'h0A9B_8000);
        checks++;
        if (bus.ir_q !== 32'h0A9B_8000) begin
            errors++;
            $display("FAIL load_ir got=%h exp=%h", bus.ir_q, 32'h0A9B_8000);
        end
        bus.Gra = 1'b1;
        bus.Rin = 1'b1;
        #1;
        checks++;
        if (bus.regin !== 16'h0020 || bus.regout !== 16'h0) begin
            errors++;
            $display("FAIL gra_rin regin=%h regout=%h exp=0020/0000",
                     bus.regin, bus.regout);
        end
        idle();
        bus.Grc  = 1'b1;
        bus.Rout = 1'b1;
        #1;
        checks++;
        if (bus.regout !== 16'h0080 || bus.regin !== 16'h0) begin
            errors++;
            $display("FAIL grc_rout regout=%h regin=%h exp=0080/0000",
                     bus.regout, bus.regin);
        end
        idle();
        bus.Grb = 1'b1;
        bus.Rin = 1'b1;
        #1;
        checks++;
        if (bus.regin !== 16'h0008) begin
            errors++;
            $display("FAIL grb_rin got=%h exp=%h", bus.regin, 16'h0008);
        end
        idle();
        bus.imm_signed = 1'b1;
        #1;
        checks++;
        if (bus.imm_out !== 32'h0003_8000) begin
            errors++;
            $display("FAIL imm_pos got=%h exp=%h", bus.imm_out, 32'h0003_8000);
        end
        idle();
    endtask

    task automatic test_priority();
        idle();
        bus.Gra  = 1'b1;
        bus.Grb  = 1'b1;
        bus.Rout = 1'b1;
        #1;
        checks++;
        if (bus.regout !== 16'h0020 || bus.sel_err !== 1'b1) begin
            errors++;
            $display("FAIL prio_ab regout=%h sel_err=%b exp=0020/1",
                     bus.regout, bus.sel_err);
        end
        bus.Gra = 1'b0;
        bus.Grc = 1'b1;
        #1;
        checks++;
        if (bus.regout !== 16'h0008 || bus.sel_err !== 1'b1) begin
            errors++;
            $display("FAIL prio_bc regout=%h sel_err=%b exp=0008/1",
                     bus.regout, bus.sel_err);
        end
        idle();
        bus.Rout = 1'b1;
        bus.Rin  = 1'b1;
        #1;
        checks++;
        if ({bus.regout, bus.regin} !== 32'h0 || bus.sel_err !== 1'b0) begin
            errors++;
            $display("FAIL no_sel regout=%h regin=%h sel_err=%b exp=0/0/0",
                     bus.regout, bus.regin, bus.sel_err);
        end
        idle();
    endtask

    task automatic test_baout();
        idle();
        load_ir(32'h0280_0000);
        bus.Grb   = 1'b1;
        bus.BAout = 1'b1;
        #1;
        checks++;
        if (bus.regout !== 16'h0001 || bus.ba_zero !== 1'b1) begin
            errors++;
            $display("FAIL ba_r0 regout=%h ba_zero=%b exp=0001/1",
                     bus.regout, bus.ba_zero);
        end
        idle();
        load_ir(32'h0020_0000);
        bus.Grb   = 1'b1;
        bus.BAout = 1'b1;
        #1;
        checks++;
        if (bus.regout !== 16'h0010 || bus.ba_zero !== 1'b0) begin
            errors++;
            $display("FAIL ba_r4 regout=%h ba_zero=%b exp=0010/0",
                     bus.regout, bus.ba_zero);
        end
        idle();
    endtask

    task automatic test_imm();
        idle();
        load_ir(32'h0007_FFFF);
        bus.imm_signed = 1'b1;
        #1;
        checks++;
        if (bus.imm_out !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL imm_sext got=%h exp=%h", bus.imm_out, 32'hFFFF_FFFF);
        end
        bus.imm_signed = 1'b0;
        #1;
        checks++;
        if (bus.imm_out !== 32'h0007_FFFF) begin
            errors++;
            $display("FAIL imm_zext got=%h exp=%h", bus.imm_out, 32'h0007_FFFF);
        end
        load_ir(32'hFFF3_FFFF);
        bus.imm_signed = 1'b1;
        #1;
        checks++;
        if (bus.imm_out !== 32'h0003_FFFF) begin
            errors++;
            $display("FAIL imm_msb0 got=%h exp=%h", bus.imm_out, 32'h0003_FFFF);
        end
        idle();
    endtask

    task automatic test_hazard();
        idle();
        load_ir(32'h0A9B_8000);
        bus.sb_reserve = 1'b1;
        #1;
        checks++;
        if (bus.stall !== 1'b0) begin
            errors++;
            $display("FAIL rsv_nostall got=%b exp=0", bus.stall);
        end
        tick();
        bus.sb_reserve = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 16'h0020) begin
            errors++;
            $display("FAIL rsv_busy got=%h exp=%h", bus.busy, 16'h0020);
        end
        bus.Gra  = 1'b1;
        bus.Rout = 1'b1;
        bus.Rin  = 1'b1;
        #1;
        checks++;
        if (bus.stall !== 1'b1 || bus.regout !== 16'h0 || bus.regin !== 16'h0) begin
            errors++;
            $display("FAIL raw_stall stall=%b regout=%h regin=%h exp=1/0/0",
                     bus.stall, bus.regout, bus.regin);
        end
        bus.Rin        = 1'b0;
        bus.sb_release = 1'b1;
        bus.sb_idx     = 4'd4;
        #1;
        checks++;
        if (bus.stall !== 1'b1) begin
            errors++;
            $display("FAIL rel_other got=%b exp=1", bus.stall);
        end
        bus.sb_idx = 4'd5;
        #1;
        checks++;
        if (bus.stall !== 1'b0 || bus.regout !== 16'h0020) begin
            errors++;
            $display("FAIL rel_bypass stall=%b regout=%h exp=0/0020",
                     bus.stall, bus.regout);
        end
        bus.Gra        = 1'b0;
        bus.Rout       = 1'b0;
        bus.sb_reserve = 1'b1;
        #1;
        checks++;
        if (bus.stall !== 1'b0) begin
            errors++;
            $display("FAIL rsv_rel_stall got=%b exp=0", bus.stall);
        end
        tick();
        idle();
        #1;
        checks++;
        if (bus.busy !== 16'h0020) begin
            errors++;
            $display("FAIL rsv_rel_busy got=%h exp=%h", bus.busy, 16'h0020);
        end
        bus.sb_reserve = 1'b1;
        bus.sb_release = 1'b1;
        bus.sb_idx     = 4'd2;
        #1;
        checks++;
        if (bus.stall !== 1'b1) begin
            errors++;
            $display("FAIL waw_stall got=%b exp=1", bus.stall);
        end
        tick();
        idle();
        #1;
        checks++;
        if (bus.busy !== 16'h0020) begin
            errors++;
            $display("FAIL waw_busy got=%h exp=%h", bus.busy, 16'h0020);
        end
        bus.sb_release = 1'b1;
        bus.sb_idx     = 4'd5;
        tick();
        idle();
        #1;
        checks++;
        if (bus.busy !== 16'h0000) begin
            errors++;
            $display("FAIL release got=%h exp=%h", bus.busy, 16'h0000);
        end
    endtask

    task automatic test_clear_mid();
        idle();
        bus.sb_reserve = 1'b1;
        tick();
        idle();
        bus.Gra   = 1'b1;
        bus.BAout = 1'b1;
        #1;
        checks++;
        if (bus.stall !== 1'b1 || bus.busy !== 16'h0020) begin
            errors++;
            $display("FAIL pre_clear stall=%b busy=%h exp=1/0020",
                     bus.stall, bus.busy);
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 16'h0 || bus.stall !== 1'b0 || bus.ir_q !== 32'h0) begin
            errors++;
            $display("FAIL clear_mid busy=%h stall=%b ir=%h exp=0/0/0",
                     bus.busy, bus.stall, bus.ir_q);
        end
        checks++;
        if (bus.regout !== 16'h0001 || bus.ba_zero !== 1'b1) begin
            errors++;
            $display("FAIL clear_ba regout=%h ba_zero=%b exp=0001/1",
                     bus.regout, bus.ba_zero);
        end
        idle();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        clear  = 1'b0;
        bus.ir_in = '0;
        idle();
        test_reset();
        test_load_decode();
        test_priority();
        test_baout();
        test_imm();
        test_hazard();
        test_clear_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
